issueq_int: RTL and testbench
=============================

Name: issueq_int

Overview:
- Integer issue queue feeding the integer execution unit in the out-of-order core.
- Holds dispatched integer/branch ops until both source operands are available, waking them up by snooping common data bus (CDB) tag broadcasts.
- Selects the oldest ready op, and on grant drives the execution unit's input bundle (ready, opcode, rsdata, rtdata, rdtag) from registers.

Parameters:
DEPTH, 4, number of queue entries (2..8)
TAGW, 6, physical register tag width
DATAW, 32, operand data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
flush  in  1  branch mispredict flush, synchronous
dispatch_valid  in  1  new op presented this cycle
dispatch_opcode  in  6  opcode/funct code (globals.v encodings)
dispatch_rsdata  in  DATAW  rs value (meaningful when rsvalid=1)
dispatch_rstag  in  TAGW  rs producer tag
dispatch_rsvalid  in  1  rs value already available
dispatch_rtdata  in  DATAW  rt value
dispatch_rttag  in  TAGW  rt producer tag
dispatch_rtvalid  in  1  rt value already available
dispatch_rdtag  in  TAGW  destination tag
iq_full  out  1  queue full; dispatcher must stall
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAGW  broadcast tag
cdb_data  in  DATAW  broadcast value
issue_request  out  1  at least one entry ready (combinational)
issue_grant  in  1  execution unit accepts an op this cycle
issueint_ready  out  1  registered; issue bundle valid this cycle
issueint_opcode  out  6  registered opcode
issueint_rsdata  out  DATAW  registered rs operand
issueint_rtdata  out  DATAW  registered rt operand
issueint_rdtag  out  TAGW  registered destination tag

Behaviour:
- Reset (reset=0, async): all entry valid bits 0, count 0, and all issueint_* outputs 0. iq_full=0, issue_request=0.
- Storage: collapsing age-ordered array. Entry 0 is the oldest and valid entries are contiguous from index 0. count holds 0..DEPTH.
- Entry ready = valid & rsvalid & rtvalid.
- issue_request = OR of entry ready bits. Only registered state is used; no same-cycle CDB bypass into select.
- Select: the lowest-index ready entry.
- Issue: if issue_request & issue_grant at an edge:
  - the selected entry's opcode, rsdata, rtdata and rdtag are loaded into the issueint_* registers, and issueint_ready=1 for the next cycle;
  - entries above the selected one shift down by one.
- If no issue occurs: issueint_ready=0 next cycle and the data outputs hold their values. Latency from an entry becoming ready to issueint_ready is 1 cycle after grant.
- Wakeup: for each valid entry with rsvalid=0 and rstag==cdb_tag while cdb_valid=1: rsdata<=cdb_data and rsvalid<=1. rt is handled identically. Both operands may wake in the same cycle.
- Dispatch: accepted when dispatch_valid & ~iq_full & ~flush. The op is written at index count, or count-1 if an issue also occurs that edge.
- A dispatching op snoops the CDB in the same cycle: a tag match with cdb_valid sets the operand valid and captures cdb_data, so no wakeup is lost.
- iq_full = (count==DEPTH), driven from state only. A dispatch while full is dropped even if an issue occurs that cycle.
- Simultaneous dispatch + issue: count unchanged.
- Simultaneous CDB wakeup of an entry + shift: the wakeup applies to the entry at its new index.
- flush=1: all valid bits cleared, count=0, issueint_ready=0 next cycle. A grant and dispatch in the same cycle are ignored. Flush has priority over all other events.
- The execution unit never stalls once granted. issue_grant without issue_request has no effect.

Decomposition:
- globals.v (shared): opcode/funct encodings (already present) plus new macros `IQ_DEPTH and `TAG_WIDTH.
- Sub-module issueq_entry: one slot containing valid/operand registers and CDB tag compare. Shift/load inputs come from the parent; it outputs ready. The parent contains the select priority encoder, count and the output registers.

Test Plan:
- Dispatch ADD, rs=5, rt=7, both valid, rdtag=3; grant held 1 -> next cycle issueint_ready=1, opcode=ADD, rsdata=5, rtdata=7, rdtag=3; following cycle ready=0.
- Dispatch SUB with rstag=9 not valid, rt=2 valid; cdb_valid=1, tag=9, data=10 two cycles later -> issue_request rises the cycle after the CDB; the issued rsdata=10.
- Same-cycle snoop: dispatch with rttag=12 invalid while CDB broadcasts tag 12, data=0xFF -> entry ready next cycle with rtdata=0xFF.
- Fill 4 unready entries -> iq_full=1. A 5th dispatch is dropped. Wake entry 2 and grant -> entry 2 issues, entries 3 shifts to 2, count=3, iq_full=0.
- Age order: entries 0 and 2 both ready, grant -> entry 0 issues first, then the former entry 2 (now index 1) on the next grant.
- Flush with 3 entries and grant asserted -> no issue (issueint_ready=0), count=0. Async reset=0 mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/issueq_int_pkg.sv
// Shared definitions for the integer issue queue: default geometry and the
// per-slot update selector driven by the queue controller.
package issueq_int_pkg;

  localparam int IQ_DEPTH   = 4;
  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;
  localparam int OPW        = 6;

  // What a slot loads at the next edge before CDB wakeup is applied.
  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_SHIFT = 2'd1,
    ENT_LOAD  = 2'd2,
    ENT_CLEAR = 2'd3
  } ent_sel_e;

endpackage

// File: rtl/issueq_int_entry.sv
// One issue-queue slot: holds an op and its operands, and snoops the CDB on
// whatever value it is about to store (held, shifted-in or dispatched).
module issueq_entry
  import issueq_int_pkg::*;
#(
  parameter int TAGW  = TAG_WIDTH,
  parameter int DATAW = DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  ent_sel_e         sel_i,
  input  logic             sh_valid_i,
  input  logic [OPW-1:0]   sh_opcode_i,
  input  logic [DATAW-1:0] sh_rsdata_i,
  input  logic [TAGW-1:0]  sh_rstag_i,
  input  logic             sh_rsvalid_i,
  input  logic [DATAW-1:0] sh_rtdata_i,
  input  logic [TAGW-1:0]  sh_rttag_i,
  input  logic             sh_rtvalid_i,
  input  logic [TAGW-1:0]  sh_rdtag_i,
  input  logic [OPW-1:0]   d_opcode_i,
  input  logic [DATAW-1:0] d_rsdata_i,
  input  logic [TAGW-1:0]  d_rstag_i,
  input  logic             d_rsvalid_i,
  input  logic [DATAW-1:0] d_rtdata_i,
  input  logic [TAGW-1:0]  d_rttag_i,
  input  logic             d_rtvalid_i,
  input  logic [TAGW-1:0]  d_rdtag_i,
  input  logic             cdb_valid_i,
  input  logic [TAGW-1:0]  cdb_tag_i,
  input  logic [DATAW-1:0] cdb_data_i,
  output logic             valid_o,
  output logic [OPW-1:0]   opcode_o,
  output logic [DATAW-1:0] rsdata_o,
  output logic [TAGW-1:0]  rstag_o,
  output logic             rsvalid_o,
  output logic [DATAW-1:0] rtdata_o,
  output logic [TAGW-1:0]  rttag_o,
  output logic             rtvalid_o,
  output logic [TAGW-1:0]  rdtag_o,
  output logic             ready_o
);

  logic             valid_q,   valid_d;
  logic [OPW-1:0]   opcode_q,  opcode_d;
  logic [DATAW-1:0] rsdata_q,  rsdata_d;
  logic [TAGW-1:0]  rstag_q,   rstag_d;
  logic             rsvalid_q, rsvalid_d;
  logic [DATAW-1:0] rtdata_q,  rtdata_d;
  logic [TAGW-1:0]  rttag_q,   rttag_d;
  logic             rtvalid_q, rtvalid_d;
  logic [TAGW-1:0]  rdtag_q,   rdtag_d;

  always_comb begin
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    rsdata_d  = rsdata_q;
    rstag_d   = rstag_q;
    rsvalid_d = rsvalid_q;
    rtdata_d  = rtdata_q;
    rttag_d   = rttag_q;
    rtvalid_d = rtvalid_q;
    rdtag_d   = rdtag_q;
    case (sel_i)
      ENT_SHIFT: begin
        valid_d   = sh_valid_i;
        opcode_d  = sh_opcode_i;
        rsdata_d  = sh_rsdata_i;
        rstag_d   = sh_rstag_i;
        rsvalid_d = sh_rsvalid_i;
        rtdata_d  = sh_rtdata_i;
        rttag_d   = sh_rttag_i;
        rtvalid_d = sh_rtvalid_i;
        rdtag_d   = sh_rdtag_i;
      end
      ENT_LOAD: begin
        valid_d   = 1'b1;
        opcode_d  = d_opcode_i;
        rsdata_d  = d_rsdata_i;
        rstag_d   = d_rstag_i;
        rsvalid_d = d_rsvalid_i;
        rtdata_d  = d_rtdata_i;
        rttag_d   = d_rttag_i;
        rtvalid_d = d_rtvalid_i;
        rdtag_d   = d_rdtag_i;
      end
      ENT_CLEAR: valid_d = 1'b0;
      default: ;
    endcase
    // Wakeup lands on the value being stored, so a shift or dispatch never loses it.
    if (cdb_valid_i && valid_d && !rsvalid_d && (rstag_d == cdb_tag_i)) begin
      rsvalid_d = 1'b1;
      rsdata_d  = cdb_data_i;
    end
    if (cdb_valid_i && valid_d && !rtvalid_d && (rttag_d == cdb_tag_i)) begin
      rtvalid_d = 1'b1;
      rtdata_d  = cdb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rsdata_q  <= '0;
      rstag_q   <= '0;
      rsvalid_q <= 1'b0;
      rtdata_q  <= '0;
      rttag_q   <= '0;
      rtvalid_q <= 1'b0;
      rdtag_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      rsdata_q  <= rsdata_d;
      rstag_q   <= rstag_d;
      rsvalid_q <= rsvalid_d;
      rtdata_q  <= rtdata_d;
      rttag_q   <= rttag_d;
      rtvalid_q <= rtvalid_d;
      rdtag_q   <= rdtag_d;
    end
  end

  assign valid_o   = valid_q;
  assign opcode_o  = opcode_q;
  assign rsdata_o  = rsdata_q;
  assign rstag_o   = rstag_q;
  assign rsvalid_o = rsvalid_q;
  assign rtdata_o  = rtdata_q;
  assign rttag_o   = rttag_q;
  assign rtvalid_o = rtvalid_q;
  assign rdtag_o   = rdtag_q;
  assign ready_o   = valid_q & rsvalid_q & rtvalid_q;

endmodule

// File: rtl/issueq_int.sv
// Integer issue queue: collapsing age-ordered slots, oldest-ready select and
// registered issue bundle toward the integer execution unit.
module issueq_int
  import issueq_int_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int TAGW  = TAG_WIDTH,
  parameter int DATAW = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [OPW-1:0]   dispatch_opcode,
  input  logic [DATAW-1:0] dispatch_rsdata,
  input  logic [TAGW-1:0]  dispatch_rstag,
  input  logic             dispatch_rsvalid,
  input  logic [DATAW-1:0] dispatch_rtdata,
  input  logic [TAGW-1:0]  dispatch_rttag,
  input  logic             dispatch_rtvalid,
  input  logic [TAGW-1:0]  dispatch_rdtag,
  output logic             iq_full,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tag,
  input  logic [DATAW-1:0] cdb_data,
  output logic             issue_request,
  input  logic             issue_grant,
  output logic             issueint_ready,
  output logic [OPW-1:0]   issueint_opcode,
  output logic [DATAW-1:0] issueint_rsdata,
  output logic [DATAW-1:0] issueint_rtdata,
  output logic [TAGW-1:0]  issueint_rdtag
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  // Slot arrays carry one extra, always-empty element so the top slot shifts in zeros.
  logic             e_valid   [DEPTH+1];
  logic [OPW-1:0]   e_opcode  [DEPTH+1];
  logic [DATAW-1:0] e_rsdata  [DEPTH+1];
  logic [TAGW-1:0]  e_rstag   [DEPTH+1];
  logic             e_rsvalid [DEPTH+1];
  logic [DATAW-1:0] e_rtdata  [DEPTH+1];
  logic [TAGW-1:0]  e_rttag   [DEPTH+1];
  logic             e_rtvalid [DEPTH+1];
  logic [TAGW-1:0]  e_rdtag   [DEPTH+1];
  logic             e_ready   [DEPTH];
  ent_sel_e         slot_sel  [DEPTH];

  logic [CNTW-1:0]  count_q, count_d;
  logic [CNTW-1:0]  wr_idx;
  logic [IDXW-1:0]  sel_idx;
  logic             any_ready;
  logic             do_issue;
  logic             do_dispatch;

  assign e_valid[DEPTH]   = 1'b0;
  assign e_opcode[DEPTH]  = '0;
  assign e_rsdata[DEPTH]  = '0;
  assign e_rstag[DEPTH]   = '0;
  assign e_rsvalid[DEPTH] = 1'b0;
  assign e_rtdata[DEPTH]  = '0;
  assign e_rttag[DEPTH]   = '0;
  assign e_rtvalid[DEPTH] = 1'b0;
  assign e_rdtag[DEPTH]   = '0;

  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (e_ready[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  // issue_request is a pure function of stored state; an issue happens on any
  // edge where issue_request and issue_grant are both high (and no flush).
  assign issue_request = any_ready;
  assign iq_full       = (count_q == CNTW'(DEPTH));
  assign do_issue      = any_ready & issue_grant & ~flush;
  assign do_dispatch   = dispatch_valid & ~iq_full & ~flush;
  assign wr_idx        = do_issue ? (count_q - 1'b1) : count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_sel[i] = ENT_HOLD;
      if (flush) begin
        slot_sel[i] = ENT_CLEAR;
      end else if (do_dispatch && (wr_idx == CNTW'(i))) begin
        slot_sel[i] = ENT_LOAD;
      end else if (do_issue && (i >= int'(sel_idx))) begin
        slot_sel[i] = (i == DEPTH - 1) ? ENT_CLEAR : ENT_SHIFT;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (do_dispatch && !do_issue) begin
      count_d = count_q + 1'b1;
    end else if (!do_dispatch && do_issue) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q         <= '0;
      issueint_ready  <= 1'b0;
      issueint_opcode <= '0;
      issueint_rsdata <= '0;
      issueint_rtdata <= '0;
      issueint_rdtag  <= '0;
    end else begin
      count_q        <= count_d;
      issueint_ready <= do_issue;
      if (do_issue) begin
        issueint_opcode <= e_opcode[sel_idx];
        issueint_rsdata <= e_rsdata[sel_idx];
        issueint_rtdata <= e_rtdata[sel_idx];
        issueint_rdtag  <= e_rdtag[sel_idx];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    issueq_entry #(.TAGW(TAGW), .DATAW(DATAW)) u_entry (
      .clk_i        (clk),
      .rst_ni       (reset),
      .sel_i        (slot_sel[g]),
      .sh_valid_i   (e_valid[g+1]),
      .sh_opcode_i  (e_opcode[g+1]),
      .sh_rsdata_i  (e_rsdata[g+1]),
      .sh_rstag_i   (e_rstag[g+1]),
      .sh_rsvalid_i (e_rsvalid[g+1]),
      .sh_rtdata_i  (e_rtdata[g+1]),
      .sh_rttag_i   (e_rttag[g+1]),
      .sh_rtvalid_i (e_rtvalid[g+1]),
      .sh_rdtag_i   (e_rdtag[g+1]),
      .d_opcode_i   (dispatch_opcode),
      .d_rsdata_i   (dispatch_rsdata),
      .d_rstag_i    (dispatch_rstag),
      .d_rsvalid_i  (dispatch_rsvalid),
      .d_rtdata_i   (dispatch_rtdata),
      .d_rttag_i    (dispatch_rttag),
      .d_rtvalid_i  (dispatch_rtvalid),
      .d_rdtag_i    (dispatch_rdtag),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_data_i   (cdb_data),
      .valid_o      (e_valid[g]),
      .opcode_o     (e_opcode[g]),
      .rsdata_o     (e_rsdata[g]),
      .rstag_o      (e_rstag[g]),
      .rsvalid_o    (e_rsvalid[g]),
      .rtdata_o     (e_rtdata[g]),
      .rttag_o      (e_rttag[g]),
      .rtvalid_o    (e_rtvalid[g]),
      .rdtag_o      (e_rdtag[g]),
      .ready_o      (e_ready[g])
    );
  end

endmodule

// File: tb/tb_issueq_int.sv
// Directed bench for issueq_int: expected issue bundles are queued as stimulus
// is applied and a monitor compares them whenever issueint_ready is high.
module tb_issueq_int;
  import issueq_int_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAGW  = 6;
  localparam int DATAW = 32;
  localparam int BW    = OPW + DATAW + DATAW + TAGW;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SLT = 6'h2a;

  logic             clk, reset, flush;
  logic             dispatch_valid;
  logic [OPW-1:0]   dispatch_opcode;
  logic [DATAW-1:0] dispatch_rsdata, dispatch_rtdata;
  logic [TAGW-1:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag;
  logic             dispatch_rsvalid, dispatch_rtvalid;
  logic             iq_full;
  logic             cdb_valid;
  logic [TAGW-1:0]  cdb_tag;
  logic [DATAW-1:0] cdb_data;
  logic             issue_request, issue_grant;
  logic             issueint_ready;
  logic [OPW-1:0]   issueint_opcode;
  logic [DATAW-1:0] issueint_rsdata, issueint_rtdata;
  logic [TAGW-1:0]  issueint_rdtag;

  int total;
  int bad;
  logic [BW-1:0] exp_q[$];

  issueq_int #(.DEPTH(DEPTH), .TAGW(TAGW), .DATAW(DATAW)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_opcode  (dispatch_opcode),
    .dispatch_rsdata  (dispatch_rsdata),
    .dispatch_rstag   (dispatch_rstag),
    .dispatch_rsvalid (dispatch_rsvalid),
    .dispatch_rtdata  (dispatch_rtdata),
    .dispatch_rttag   (dispatch_rttag),
    .dispatch_rtvalid (dispatch_rtvalid),
    .dispatch_rdtag   (dispatch_rdtag),
    .iq_full          (iq_full),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .issue_request    (issue_request),
    .issue_grant      (issue_grant),
    .issueint_ready   (issueint_ready),
    .issueint_opcode  (issueint_opcode),
    .issueint_rsdata  (issueint_rsdata),
    .issueint_rtdata  (issueint_rtdata),
    .issueint_rdtag   (issueint_rdtag)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] bundle(input logic [OPW-1:0] op, input logic [DATAW-1:0] rs,
                                           input logic [DATAW-1:0] rt, input logic [TAGW-1:0] rd);
    return {op, rs, rt, rd};
  endfunction

  // Driver tasks
  task automatic dispatch_op(input logic [OPW-1:0] op,
                             input logic [DATAW-1:0] rs, input logic [TAGW-1:0] rstag, input logic rsv,
                             input logic [DATAW-1:0] rt, input logic [TAGW-1:0] rttag, input logic rtv,
                             input logic [TAGW-1:0] rd);
    dispatch_opcode  = op;
    dispatch_rsdata  = rs;
    dispatch_rstag   = rstag;
    dispatch_rsvalid = rsv;
    dispatch_rtdata  = rt;
    dispatch_rttag   = rttag;
    dispatch_rtvalid = rtv;
    dispatch_rdtag   = rd;
    dispatch_valid   = 1'b1;
    step();
    dispatch_valid   = 1'b0;
  endtask

  task automatic broadcast(input logic [TAGW-1:0] tag, input logic [DATAW-1:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    step();
    cdb_valid = 1'b0;
  endtask

  // Scoreboard monitor
  task automatic monitor();
    logic [BW-1:0] e;
    forever begin
      @(negedge clk);
      if (issueint_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %h expected none",
                   {issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag});
        end else begin
          e = exp_q.pop_front();
          chk_bundle("issue_bundle",
                     {issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag}, e);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_opcode = '0;
    dispatch_rsdata = '0;
    dispatch_rstag = '0;
    dispatch_rsvalid = 1'b0;
    dispatch_rtdata = '0;
    dispatch_rttag = '0;
    dispatch_rtvalid = 1'b0;
    dispatch_rdtag = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    issue_grant = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) step();
    chk1("rst_ready", issueint_ready, 1'b0);
    chk1("rst_full", iq_full, 1'b0);
    chk1("rst_request", issue_request, 1'b0);
    chk_bundle("rst_bundle", {issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag}, '0);
    reset = 1'b1;
    step();

    // Ready-at-dispatch op with grant held high
    issue_grant = 1'b1;
    exp_q.push_back(bundle(OP_ADD, 32'd5, 32'd7, 6'd3));
    dispatch_op(OP_ADD, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3);
    chk1("t1_request", issue_request, 1'b1);
    step();
    chk1("t1_ready_hi", issueint_ready, 1'b1);
    step();
    chk1("t1_ready_lo", issueint_ready, 1'b0);
    chk1("t1_request_lo", issue_request, 1'b0);

    // rs woken by CDB two cycles after dispatch
    exp_q.push_back(bundle(OP_SUB, 32'd10, 32'd2, 6'd4));
    dispatch_op(OP_SUB, 32'd0, 6'd9, 1'b0, 32'd2, 6'd0, 1'b1, 6'd4);
    chk1("t2_wait", issue_request, 1'b0);
    step();
    chk1("t2_wait2", issue_request, 1'b0);
    broadcast(6'd9, 32'd10);
    chk1("t2_wakeup", issue_request, 1'b1);
    step();
    chk1("t2_ready", issueint_ready, 1'b1);
    issue_grant = 1'b0;
    step();

    // Same-cycle snoop on a dispatching op
    cdb_valid = 1'b1;
    cdb_tag   = 6'd12;
    cdb_data  = 32'hFF;
    exp_q.push_back(bundle(OP_AND, 32'd1, 32'hFF, 6'd5));
    dispatch_op(OP_AND, 32'd1, 6'd0, 1'b1, 32'd0, 6'd12, 1'b0, 6'd5);
    cdb_valid = 1'b0;
    chk1("t3_snoop", issue_request, 1'b1);
    issue_grant = 1'b1;
    step();
    issue_grant = 1'b0;
    chk1("t3_ready", issueint_ready, 1'b1);

    // Fill with unready ops, drop a dispatch while full
    dispatch_op(OP_OR,  32'd0, 6'd20, 1'b0, 32'h11, 6'd0, 1'b1, 6'd10);
    dispatch_op(OP_XOR, 32'd0, 6'd21, 1'b0, 32'h12, 6'd0, 1'b1, 6'd11);
    chk1("t4_not_full", iq_full, 1'b0);
    dispatch_op(OP_SLT, 32'd0, 6'd22, 1'b0, 32'h13, 6'd0, 1'b1, 6'd12);
    dispatch_op(OP_ADD, 32'd0, 6'd23, 1'b0, 32'h14, 6'd0, 1'b1, 6'd13);
    chk1("t4_full", iq_full, 1'b1);
    chk1("t4_none_ready", issue_request, 1'b0);
    dispatch_op(OP_SUB, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'd14);
    chk1("t4_drop_full", iq_full, 1'b1);
    chk1("t4_drop_req", issue_request, 1'b0);
    broadcast(6'd22, 32'h222);
    chk1("t4_wake2", issue_request, 1'b1);
    exp_q.push_back(bundle(OP_SLT, 32'h222, 32'h13, 6'd12));
    issue_grant = 1'b1;
    step();
    issue_grant = 1'b0;
    chk1("t4_after_issue", iq_full, 1'b0);
    dispatch_op(OP_SUB, 32'h30, 6'd0, 1'b1, 32'h31, 6'd0, 1'b1, 6'd9);
    chk1("t4_count3_refill", iq_full, 1'b1);

    // Age order: entries 0 and 2 ready, plus newest entry 3
    broadcast(6'd23, 32'h333);
    broadcast(6'd20, 32'h111);
    exp_q.push_back(bundle(OP_OR,  32'h111, 32'h11, 6'd10));
    exp_q.push_back(bundle(OP_ADD, 32'h333, 32'h14, 6'd13));
    exp_q.push_back(bundle(OP_SUB, 32'h30,  32'h31, 6'd9));
    issue_grant = 1'b1;
    repeat (3) step();
    issue_grant = 1'b0;
    chk1("t5_left_unready", issue_request, 1'b0);
    chk1("t5_not_full", iq_full, 1'b0);

    // Flush with three entries, grant and dispatch in the same cycle
    dispatch_op(OP_ADD, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd20);
    dispatch_op(OP_ADD, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd21);
    chk1("t6_pre_request", issue_request, 1'b1);
    flush = 1'b1;
    issue_grant = 1'b1;
    dispatch_op(OP_SUB, 32'd5, 6'd0, 1'b1, 32'd6, 6'd0, 1'b1, 6'd22);
    flush = 1'b0;
    issue_grant = 1'b0;
    chk1("t6_no_issue", issueint_ready, 1'b0);
    chk1("t6_request", issue_request, 1'b0);
    chk1("t6_full", iq_full, 1'b0);
    dispatch_op(OP_OR, 32'd0, 6'd50, 1'b0, 32'd0, 6'd0, 1'b1, 6'd30);
    dispatch_op(OP_OR, 32'd0, 6'd51, 1'b0, 32'd0, 6'd0, 1'b1, 6'd31);
    dispatch_op(OP_OR, 32'd0, 6'd52, 1'b0, 32'd0, 6'd0, 1'b1, 6'd32);
    chk1("t6_count3", iq_full, 1'b0);
    dispatch_op(OP_OR, 32'd0, 6'd53, 1'b0, 32'd0, 6'd0, 1'b1, 6'd33);
    chk1("t6_count4", iq_full, 1'b1);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    chk1("t7_full", iq_full, 1'b0);
    chk1("t7_request", issue_request, 1'b0);
    chk1("t7_ready", issueint_ready, 1'b0);
    chk_bundle("t7_bundle", {issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag}, '0);
    step();
    reset = 1'b1;
    repeat (3) step();

    chk1("queue_drained", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
